// File: rtl/calc.sv
// -----------------------------------------------------------------------------
// calc : six-digit decimal keypad calculator (add / subtract)
//
// Takes key codes from an upstream keyboard decoder, one key per rising edge
// of data_ready, and drives six BCD digits to the 7-segment display driver.
//
// Ports
//   CLK        in   1  system clock, all state updates on the rising edge
//   RST_N      in   1  asynchronous active-low reset
//   data_ready in   1  key-valid strobe, a key is taken on its 0->1 transition
//   hex_data   in   8  key code, sampled on the clock that sees the edge
//   Dig0..Dig5 out  4  displayed value in BCD, Dig0 = units ... Dig5 = 10^5
//
// Key codes: 0x00-0x09 digits, 0x1E '+', 0x1F '-', 0x0C '=', 0x12 clear.
// Any other code is ignored.
// -----------------------------------------------------------------------------
module calc (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       data_ready,
    input  logic [7:0] hex_data,
    output logic [3:0] Dig0,
    output logic [3:0] Dig1,
    output logic [3:0] Dig2,
    output logic [3:0] Dig3,
    output logic [3:0] Dig4,
    output logic [3:0] Dig5
);

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t      state;
    logic [23:0] a_bcd;
    logic [23:0] b_bcd;
    logic [23:0] disp;
    logic        op_sub;
    logic        data_ready_q;

    logic        key_evt;
    logic        is_digit;
    logic        is_plus;
    logic        is_minus;
    logic        is_eq;
    logic        is_clear;
    logic [3:0]  digit;
    logic [23:0] result;

    // Six BCD digits -> binary (max 999999 fits in 20 bits).
    function automatic logic [19:0] bcd_to_bin(input logic [23:0] v);
        logic [19:0] r;
        r = '0;
        for (int i = 5; i >= 0; i--) begin
            r = r * 20'd10 + {16'd0, v[i*4 +: 4]};
        end
        return r;
    endfunction

    // Binary (< 1,000,000) -> six BCD digits, shift-and-add-3.
    function automatic logic [23:0] bin_to_bcd(input logic [19:0] v);
        logic [23:0] bcd;
        bcd = '0;
        for (int i = 19; i >= 0; i--) begin
            for (int d = 0; d < 6; d++) begin
                if (bcd[d*4 +: 4] >= 4'd5) begin
                    bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
                end
            end
            bcd = {bcd[22:0], v[i]};
        end
        return bcd;
    endfunction

    // A op B. The add keeps one extra carry bit so that the modulo-1,000,000
    // wrap is exact even for 999999 + 999999.
    function automatic logic [23:0] apply_op(input logic [23:0] a,
                                             input logic [23:0] b,
                                             input logic        sub);
        logic [19:0] ab;
        logic [19:0] bb;
        logic [19:0] res;
        logic [20:0] sum;
        ab  = bcd_to_bin(a);
        bb  = bcd_to_bin(b);
        sum = {1'b0, ab} + {1'b0, bb};
        if (sub) begin
            res = (ab >= bb) ? (ab - bb) : 20'd0;
        end else begin
            if (sum >= 21'd1000000) begin
                sum = sum - 21'd1000000;
            end
            res = sum[19:0];
        end
        return bin_to_bcd(res);
    endfunction

    // Digit entry is a BCD left shift; once the top digit is significant
    // the operand is full and further digits are dropped.
    function automatic logic [23:0] shift_in(input logic [23:0] v,
                                             input logic [3:0]  d);
        return (v[23:20] != 4'd0) ? v : {v[19:0], d};
    endfunction

    assign key_evt  = data_ready & ~data_ready_q;
    assign is_digit = (hex_data <= 8'h09);
    assign is_plus  = (hex_data == 8'h1E);
    assign is_minus = (hex_data == 8'h1F);
    assign is_eq    = (hex_data == 8'h0C);
    assign is_clear = (hex_data == 8'h12);
    assign digit    = hex_data[3:0];
    assign result   = apply_op(a_bcd, b_bcd, op_sub);

    // data_ready_q resets to 1 so a strobe already high at reset release
    // must fall and rise again before it counts as a key.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_ready_q <= 1'b1;
            state        <= ENTRY_A;
            a_bcd        <= '0;
            b_bcd        <= '0;
            disp         <= '0;
            op_sub       <= 1'b0;
        end else begin
            data_ready_q <= data_ready;
            if (key_evt) begin
                if (is_clear) begin
                    state  <= ENTRY_A;
                    a_bcd  <= '0;
                    b_bcd  <= '0;
                    disp   <= '0;
                    op_sub <= 1'b0;
                end else if (is_digit) begin
                    case (state)
                        ENTRY_A: begin
                            a_bcd <= shift_in(a_bcd, digit);
                            disp  <= shift_in(a_bcd, digit);
                        end
                        ENTRY_B: begin
                            b_bcd <= shift_in(b_bcd, digit);
                            disp  <= shift_in(b_bcd, digit);
                        end
                        RESULT: begin
                            a_bcd <= {20'd0, digit};
                            disp  <= {20'd0, digit};
                            state <= ENTRY_A;
                        end
                        default: state <= ENTRY_A;
                    endcase
                end else if (is_plus || is_minus) begin
                    // In ENTRY_B an operator chains: fold the pending
                    // operation into A before latching the new operator.
                    if (state == ENTRY_B) begin
                        a_bcd <= result;
                        disp  <= result;
                    end
                    op_sub <= is_minus;
                    b_bcd  <= '0;
                    state  <= ENTRY_B;
                end else if (is_eq) begin
                    // '=' in RESULT repeats the last operation with the same B.
                    if (state != ENTRY_A) begin
                        a_bcd <= result;
                        disp  <= result;
                        state <= RESULT;
                    end
                end
            end
        end
    end

    assign Dig0 = disp[3:0];
    assign Dig1 = disp[7:4];
    assign Dig2 = disp[11:8];
    assign Dig3 = disp[15:12];
    assign Dig4 = disp[19:16];
    assign Dig5 = disp[23:20];

endmodule

// File: tb/tb_calc.sv
// -----------------------------------------------------------------------------
// tb_calc : self-checking bench for calc.
//
// Directed key sequences followed by random key traffic; every display value
// is compared with a decimal reference model of the calculator kept here.
// -----------------------------------------------------------------------------
module tb_calc;

    logic       CLK;
    logic       RST_N;
    logic       data_ready;
    logic [7:0] hex_data;
    logic [3:0] Dig0, Dig1, Dig2, Dig3, Dig4, Dig5;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain integers, state as 0=entering A, 1=entering B,
    // 2=showing a result.
    int m_a, m_b, m_st, m_disp;
    bit m_sub;

    calc dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .data_ready (data_ready),
        .hex_data   (hex_data),
        .Dig0       (Dig0),
        .Dig1       (Dig1),
        .Dig2       (Dig2),
        .Dig3       (Dig3),
        .Dig4       (Dig4),
        .Dig5       (Dig5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    function automatic logic [23:0] disp_now();
        return {Dig5, Dig4, Dig3, Dig2, Dig1, Dig0};
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%06h expected=%06h", tag, obs, expv);
        end
    endtask

    function automatic int do_op(input int a, input int b, input bit sub);
        if (sub) return (a >= b) ? a - b : 0;
        return (a + b) % 1000000;
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_st = 0; m_disp = 0; m_sub = 1'b0;
    endtask

    task automatic model_key(input logic [7:0] k);
        if (k <= 8'h09) begin
            if (m_st == 0) begin
                if (m_a < 100000) m_a = m_a * 10 + int'(k);
                m_disp = m_a;
            end else if (m_st == 1) begin
                if (m_b < 100000) m_b = m_b * 10 + int'(k);
                m_disp = m_b;
            end else begin
                m_a = int'(k);
                m_disp = m_a;
                m_st = 0;
            end
        end else if (k == 8'h1E || k == 8'h1F) begin
            if (m_st == 1) begin
                m_a = do_op(m_a, m_b, m_sub);
                m_disp = m_a;
            end
            m_sub = (k == 8'h1F);
            m_b = 0;
            m_st = 1;
        end else if (k == 8'h0C) begin
            if (m_st != 0) begin
                m_a = do_op(m_a, m_b, m_sub);
                m_disp = m_a;
                m_st = 2;
            end
        end else if (k == 8'h12) begin
            model_reset();
        end
    endtask

    // One key stroke: strobe held for 'hold' clocks; the display must show
    // the effect one edge after the strobe rises and stay put while held.
    task automatic press(input logic [7:0] code, input int hold);
        @(negedge CLK);
        hex_data   = code;
        data_ready = 1'b1;
        @(posedge CLK);
        #1;
        model_key(code);
        check("key", disp_now(), to_bcd(m_disp));
        for (int i = 1; i < hold; i++) begin
            @(negedge CLK);
            hex_data = 8'($urandom_range(0, 9));
            @(posedge CLK);
            #1;
            check("held_strobe", disp_now(), to_bcd(m_disp));
        end
        @(negedge CLK);
        data_ready = 1'b0;
        hex_data   = 8'($urandom);
    endtask

    initial begin
        logic [7:0] code;
        int r;

        RST_N      = 1'b0;
        data_ready = 1'b0;
        hex_data   = 8'h00;
        model_reset();
        #12;
        check("reset_state", disp_now(), 24'h000000);
        @(negedge CLK);
        RST_N = 1'b1;

        // 112 + 2 = 114
        press(8'h12, 1);
        press(8'h01, 1);
        press(8'h01, 1);
        press(8'h02, 1);
        check("entry_112", disp_now(), 24'h000112);
        press(8'h1E, 1);
        check("plus_keeps_a", disp_now(), 24'h000112);
        press(8'h02, 1);
        check("entry_b_2", disp_now(), 24'h000002);
        press(8'h0C, 1);
        check("sum_114", disp_now(), 24'h000114);

        // long strobe gives exactly one digit
        press(8'h12, 1);
        press(8'h07, 5);
        check("long_strobe", disp_now(), 24'h000007);

        // overflow wraps modulo 1,000,000; seventh digit ignored
        press(8'h12, 1);
        for (int i = 0; i < 6; i++) press(8'h09, 1);
        press(8'h05, 1);
        check("seventh_digit", disp_now(), 24'h999999);
        press(8'h1E, 1);
        press(8'h02, 1);
        press(8'h0C, 1);
        check("add_wrap", disp_now(), 24'h000001);

        // subtract clamps at zero, '=' repeats
        press(8'h12, 1);
        press(8'h03, 1);
        press(8'h1F, 1);
        press(8'h05, 1);
        press(8'h0C, 1);
        check("sub_clamp", disp_now(), 24'h000000);
        press(8'h0C, 1);
        check("repeat_clamp", disp_now(), 24'h000000);

        // chained operators
        press(8'h12, 1);
        press(8'h01, 1);
        press(8'h00, 1);
        press(8'h1E, 1);
        press(8'h05, 1);
        press(8'h1F, 1);
        check("chain_15", disp_now(), 24'h000015);
        press(8'h03, 1);
        press(8'h0C, 1);
        check("chain_12", disp_now(), 24'h000012);
        press(8'h0C, 1);
        check("repeat_sub_9", disp_now(), 24'h000009);

        // asynchronous reset in the middle of entering B, strobe held across release
        press(8'h12, 1);
        press(8'h04, 1);
        press(8'h1E, 1);
        press(8'h06, 1);
        press(8'h07, 1);
        check("before_reset", disp_now(), 24'h000067);
        @(negedge CLK);
        hex_data   = 8'h05;
        data_ready = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check("async_reset", disp_now(), 24'h000000);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("no_event_after_reset", disp_now(), 24'h000000);
        @(negedge CLK);
        data_ready = 1'b0;
        press(8'h55, 1);
        check("unknown_ignored", disp_now(), 24'h000000);
        press(8'h08, 1);
        press(8'h55, 2);
        check("unknown_after_digit", disp_now(), 24'h000008);

        // random key traffic against the model
        press(8'h12, 1);
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 39));
            if (r < 24)      code = 8'($urandom_range(0, 9));
            else if (r < 28) code = 8'h1E;
            else if (r < 32) code = 8'h1F;
            else if (r < 37) code = 8'h0C;
            else if (r == 37) code = 8'h12;
            else             code = 8'($urandom);
            press(code, int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
